// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the three-way memory port arbiter.
package mem_port_arbiter_pkg;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_LDR = 2'd0;
  localparam req_id_t REQ_LSU = 2'd1;
  localparam req_id_t REQ_IFU = 2'd2;

  localparam logic [3:0] BE_FULL = 4'hF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, grouped in one bundle.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              ldr_req;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_done;

  logic              lsu_req;
  logic              lsu_we;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic [3:0]        lsu_be;
  logic              lsu_gnt;
  logic              lsu_done;

  logic              ifu_req;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_gnt;
  logic              ifu_done;

  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view.
  modport slave (
    input  ldr_req, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_done,
    input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_be,
    output lsu_gnt, lsu_done,
    input  ifu_req, ifu_addr,
    output ifu_gnt, ifu_done,
    output rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  // Requesters plus memory, as seen from outside the arbiter.
  modport master (
    output ldr_req, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_done,
    output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_be,
    input  lsu_gnt, lsu_done,
    output ifu_req, ifu_addr,
    input  ifu_gnt, ifu_done,
    input  rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick between lsu and ifu.
module mem_port_arbiter_rr_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic    i_lsu_req,
  input  logic    i_ifu_req,
  input  req_id_t i_rr_last,
  output req_id_t o_winner
);

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    o_winner = REQ_LSU;
    if (i_lsu_req && i_ifu_req) begin
      o_winner = (i_rr_last == REQ_LSU) ? REQ_IFU : REQ_LSU;
    end else if (i_ifu_req) begin
      o_winner = REQ_IFU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises loader, lsu and ifu accesses onto one single-port memory, with a
// ready-timeout watchdog that aborts a stalled transaction.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic                i_clk,
  input logic                i_rst,
  mem_port_arbiter_if.slave  io_bus
);

  localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  state_e            r_state, w_state_next;
  req_id_t           r_owner, r_rr_last, w_rr_winner, w_winner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [WDOG_W-1:0] r_wdog;
  logic              w_any_req, w_grant, w_ready, w_abort;

  mem_port_arbiter_rr_pick2 u_rr_pick2 (
    .i_lsu_req (io_bus.lsu_req),
    .i_ifu_req (io_bus.ifu_req),
    .i_rr_last (r_rr_last),
    .o_winner  (w_rr_winner)
  );

  assign w_any_req = io_bus.ldr_req | io_bus.lsu_req | io_bus.ifu_req;
  assign w_winner  = io_bus.ldr_req ? REQ_LDR : w_rr_winner;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    w_grant         = 1'b0;
    w_ready         = 1'b0;
    w_abort         = 1'b0;
    io_bus.ldr_gnt  = 1'b0;
    io_bus.lsu_gnt  = 1'b0;
    io_bus.ifu_gnt  = 1'b0;
    io_bus.ldr_done = 1'b0;
    io_bus.lsu_done = 1'b0;
    io_bus.ifu_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_grant      = 1'b1;
          w_state_next = StBusy;
          unique case (w_winner)
            REQ_LDR: io_bus.ldr_gnt = 1'b1;
            REQ_LSU: io_bus.lsu_gnt = 1'b1;
            REQ_IFU: io_bus.ifu_gnt = 1'b1;
            default: ;
          endcase
        end
      end
      StBusy: begin
        // A ready arriving on the last watchdog cycle still completes normally.
        if (io_bus.mem_ready) begin
          w_ready      = 1'b1;
          w_state_next = StResp;
        end else if (r_wdog == WDOG_LAST) begin
          w_abort      = 1'b1;
          w_state_next = StResp;
        end
      end
      StResp: begin
        w_state_next = StIdle;
        unique case (r_owner)
          REQ_LDR: io_bus.ldr_done = 1'b1;
          REQ_LSU: io_bus.lsu_done = 1'b1;
          REQ_IFU: io_bus.ifu_done = 1'b1;
          default: ;
        endcase
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner   <= REQ_LDR;
      r_rr_last <= REQ_IFU;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_wdog    <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_winner;
        r_wdog  <= '0;
        unique case (w_winner)
          REQ_LDR: begin
            r_we    <= 1'b1;
            r_addr  <= io_bus.ldr_addr;
            r_wdata <= io_bus.ldr_wdata;
            r_be    <= BE_FULL;
          end
          REQ_LSU: begin
            r_we      <= io_bus.lsu_we;
            r_addr    <= io_bus.lsu_addr;
            r_wdata   <= io_bus.lsu_wdata;
            r_be      <= io_bus.lsu_be;
            r_rr_last <= REQ_LSU;
          end
          REQ_IFU: begin
            r_we      <= 1'b0;
            r_addr    <= io_bus.ifu_addr;
            r_wdata   <= '0;
            r_be      <= BE_FULL;
            r_rr_last <= REQ_IFU;
          end
          default: ;
        endcase
      end
      if (r_state == StBusy) r_wdog <= r_wdog + WDOG_W'(1);
      if (w_ready) begin
        r_err <= 1'b0;
        if (!r_we) r_rdata <= io_bus.mem_rdata;
      end
      if (w_abort) begin
        r_err   <= 1'b1;
        r_rdata <= '0;
      end
    end
  end

  assign io_bus.mem_req   = (r_state == StBusy);
  assign io_bus.mem_we    = r_we;
  assign io_bus.mem_addr  = r_addr;
  assign io_bus.mem_wdata = r_wdata;
  assign io_bus.mem_be    = r_be;
  assign io_bus.rsp_rdata = r_rdata;
  assign io_bus.rsp_err   = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one task per scenario, inline checks.
module tb_mem_port_arbiter;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .io_bus (bus)
  );

  int checks = 0;
  int passes = 0;

  // Memory model: ready on the mem_delay-th cycle of mem_req; 0 = never ready.
  int          mem_delay = 1;
  int          busy_cnt = 0;
  logic [31:0] mem_rdata_v = '0;

  always @(posedge i_clk) begin
    if (i_rst || !bus.mem_req) busy_cnt <= 0;
    else                       busy_cnt <= busy_cnt + 1;
  end
  assign bus.mem_ready = bus.mem_req && (mem_delay != 0) && (busy_cnt == mem_delay - 1);
  assign bus.mem_rdata = mem_rdata_v;

  // Inputs change at posedge+1; outputs are sampled at posedge+2.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
  endtask

  task automatic wait_gnt(output int id, output bit ok);
    ok = 1'b0;
    id = -1;
    for (int n = 0; n < 10; n++) begin
      if (bus.ldr_gnt) begin id = 0; ok = 1'b1; return; end
      if (bus.lsu_gnt) begin id = 1; ok = 1'b1; return; end
      if (bus.ifu_gnt) begin id = 2; ok = 1'b1; return; end
      step();
      #1;
    end
  endtask

  task automatic ifu_txn(input logic [31:0] addr, input int delay, input logic [31:0] rdata,
                         output bit gnt_ok, output int n_req, output int n_done,
                         output logic [31:0] d_rdata, output logic d_err);
    mem_delay   = delay;
    mem_rdata_v = rdata;
    step();
    bus.ifu_req  = 1'b1;
    bus.ifu_addr = addr;
    #1;
    gnt_ok = bus.ifu_gnt;
    step();
    bus.ifu_req = 1'b0;
    n_req   = 0;
    n_done  = 0;
    d_rdata = 'x;
    d_err   = 1'bx;
    for (int n = 0; n < 24; n++) begin
      #1;
      if (bus.mem_req) n_req++;
      if (bus.ifu_done) begin
        n_done++;
        d_rdata = bus.rsp_rdata;
        d_err   = bus.rsp_err;
      end
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({bus.mem_req, bus.ldr_gnt, bus.lsu_gnt, bus.ifu_gnt,
         bus.ldr_done, bus.lsu_done, bus.ifu_done} !== 7'b0)
      $display("FAIL reset_ctrl: got %b want 0", {bus.mem_req, bus.ldr_gnt, bus.lsu_gnt,
               bus.ifu_gnt, bus.ldr_done, bus.lsu_done, bus.ifu_done});
    else passes++;
    checks++;
    if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== '0)
      $display("FAIL reset_cmd: we=%b addr=%h wdata=%h be=%h want 0",
               bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be);
    else passes++;
    checks++;
    if (bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0)
      $display("FAIL reset_rsp: rdata=%h err=%b want 0/0", bus.rsp_rdata, bus.rsp_err);
    else passes++;
  endtask

  task automatic test_fetch();
    mem_delay   = 1;
    mem_rdata_v = 32'h0000_0513;
    step();
    bus.ifu_req  = 1'b1;
    bus.ifu_addr = 32'h10;
    #1;
    checks++;
    if (bus.ifu_gnt !== 1'b1 || bus.lsu_gnt !== 1'b0 || bus.ldr_gnt !== 1'b0)
      $display("FAIL fetch_gnt_T: ifu=%b lsu=%b ldr=%b want 1/0/0",
               bus.ifu_gnt, bus.lsu_gnt, bus.ldr_gnt);
    else passes++;
    step();
    bus.ifu_req = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h10 || bus.mem_we !== 1'b0 ||
        bus.mem_be !== 4'hF || bus.ifu_gnt !== 1'b0)
      $display("FAIL fetch_mem_T1: req=%b addr=%h we=%b be=%h gnt=%b want 1/10/0/f/0",
               bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_be, bus.ifu_gnt);
    else passes++;
    step();
    #1;
    checks++;
    if (bus.ifu_done !== 1'b1 || bus.mem_req !== 1'b0 || bus.rsp_rdata !== 32'h0000_0513 ||
        bus.rsp_err !== 1'b0)
      $display("FAIL fetch_done_T2: done=%b req=%b rdata=%h err=%b want 1/0/00000513/0",
               bus.ifu_done, bus.mem_req, bus.rsp_rdata, bus.rsp_err);
    else passes++;
    step();
    #1;
    checks++;
    if (bus.ifu_done !== 1'b0)
      $display("FAIL fetch_done_pulse: done=%b want 0", bus.ifu_done);
    else passes++;
  endtask

  task automatic test_round_robin();
    int id;
    bit ok;
    int want [4] = '{1, 2, 1, 2};
    do_reset();
    mem_delay = 1;
    step();
    bus.lsu_req   = 1'b1;
    bus.lsu_we    = 1'b0;
    bus.lsu_addr  = 32'h20;
    bus.lsu_be    = 4'hF;
    bus.ifu_req   = 1'b1;
    bus.ifu_addr  = 32'h30;
    #1;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(id, ok);
      checks++;
      if (!ok || id !== want[i])
        $display("FAIL rr_order_%0d: winner=%0d want %0d", i, id, want[i]);
      else passes++;
      if (i < 3) begin
        step();
        #1;
      end
    end
    step();
    bus.lsu_req = 1'b0;
    bus.ifu_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_ldr_priority();
    int id;
    bit ok;
    mem_delay   = 1;
    mem_rdata_v = 32'hCAFE_F00D;
    step();
    bus.ldr_req   = 1'b1;
    bus.ldr_addr  = 32'h4;
    bus.ldr_wdata = 32'hDEAD_BEEF;
    bus.lsu_req   = 1'b1;
    bus.ifu_req   = 1'b1;
    #1;
    checks++;
    if (bus.ldr_gnt !== 1'b1 || bus.lsu_gnt !== 1'b0 || bus.ifu_gnt !== 1'b0)
      $display("FAIL ldr_prio_gnt: ldr=%b lsu=%b ifu=%b want 1/0/0",
               bus.ldr_gnt, bus.lsu_gnt, bus.ifu_gnt);
    else passes++;
    step();
    bus.ldr_req   = 1'b0;
    bus.ldr_wdata = 32'h0;
    #1;
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_be !== 4'hF || bus.mem_wdata !== 32'hDEAD_BEEF ||
        bus.mem_addr !== 32'h4)
      $display("FAIL ldr_cmd: we=%b be=%h wdata=%h addr=%h want 1/f/deadbeef/4",
               bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr);
    else passes++;
    step();
    #1;
    checks++;
    if (bus.ldr_done !== 1'b1 || bus.lsu_done !== 1'b0 || bus.ifu_done !== 1'b0)
      $display("FAIL ldr_done: ldr=%b lsu=%b ifu=%b want 1/0/0",
               bus.ldr_done, bus.lsu_done, bus.ifu_done);
    else passes++;
    wait_gnt(id, ok);
    checks++;
    if (!ok || id !== 1) $display("FAIL ldr_then_lsu: winner=%0d want 1", id);
    else passes++;
    step();
    bus.lsu_req = 1'b0;
    #1;
    wait_gnt(id, ok);
    checks++;
    if (!ok || id !== 2) $display("FAIL ldr_then_ifu: winner=%0d want 2", id);
    else passes++;
    step();
    bus.ifu_req = 1'b0;
    step();
    #1;
    checks++;
    if (bus.ifu_done !== 1'b1 || bus.rsp_rdata !== 32'hCAFE_F00D)
      $display("FAIL ldr_ifu_read: done=%b rdata=%h want 1/cafef00d",
               bus.ifu_done, bus.rsp_rdata);
    else passes++;
    step();
  endtask

  task automatic test_store_delay();
    int n_req = 0;
    int n_done = 0;
    bit unstable = 1'b0;
    logic [31:0] d_rdata = 'x;
    mem_delay   = 5;
    mem_rdata_v = 32'hFFFF_0000;
    step();
    bus.lsu_req   = 1'b1;
    bus.lsu_we    = 1'b1;
    bus.lsu_be    = 4'b0011;
    bus.lsu_addr  = 32'h8;
    bus.lsu_wdata = 32'h1234_ABCD;
    #1;
    checks++;
    if (bus.lsu_gnt !== 1'b1) $display("FAIL store_gnt: gnt=%b want 1", bus.lsu_gnt);
    else passes++;
    step();
    // Payload changes after the grant must not reach the memory.
    bus.lsu_req   = 1'b0;
    bus.lsu_we    = 1'b0;
    bus.lsu_be    = 4'hF;
    bus.lsu_addr  = 32'hFFFC;
    bus.lsu_wdata = 32'h0;
    for (int n = 0; n < 12; n++) begin
      #1;
      if (bus.mem_req) begin
        n_req++;
        if (bus.mem_we !== 1'b1 || bus.mem_be !== 4'b0011 || bus.mem_addr !== 32'h8 ||
            bus.mem_wdata !== 32'h1234_ABCD) unstable = 1'b1;
      end
      if (bus.lsu_done) begin
        n_done++;
        d_rdata = bus.rsp_rdata;
      end
      step();
    end
    checks++;
    if (n_req !== 5) $display("FAIL store_req_cycles: got %0d want 5", n_req);
    else passes++;
    checks++;
    if (unstable !== 1'b0) $display("FAIL store_payload_stable: unstable=%b want 0", unstable);
    else passes++;
    checks++;
    if (n_done !== 1) $display("FAIL store_done_count: got %0d want 1", n_done);
    else passes++;
    checks++;
    if (d_rdata !== 32'hCAFE_F00D || bus.rsp_err !== 1'b0)
      $display("FAIL store_rdata_kept: rdata=%h err=%b want cafef00d/0", d_rdata, bus.rsp_err);
    else passes++;
  endtask

  task automatic test_timeout();
    bit gnt_ok;
    int n_req, n_done;
    logic [31:0] d_rdata;
    logic d_err;
    ifu_txn(32'h40, 0, 32'h1111_1111, gnt_ok, n_req, n_done, d_rdata, d_err);
    checks++;
    if (!gnt_ok || n_req !== 16 || n_done !== 1)
      $display("FAIL timeout_cycles: gnt=%b req_cycles=%0d dones=%0d want 1/16/1",
               gnt_ok, n_req, n_done);
    else passes++;
    checks++;
    if (d_err !== 1'b1 || d_rdata !== 32'h0)
      $display("FAIL timeout_rsp: err=%b rdata=%h want 1/0", d_err, d_rdata);
    else passes++;
    ifu_txn(32'h44, 1, 32'h0000_600D, gnt_ok, n_req, n_done, d_rdata, d_err);
    checks++;
    if (!gnt_ok || n_req !== 1 || n_done !== 1 || d_err !== 1'b0 || d_rdata !== 32'h600D)
      $display("FAIL after_timeout: gnt=%b req=%0d done=%0d err=%b rdata=%h want 1/1/1/0/600d",
               gnt_ok, n_req, n_done, d_err, d_rdata);
    else passes++;
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    int id;
    bit ok, gnt_ok;
    int n_req, n_done2;
    logic [31:0] d_rdata;
    logic d_err;
    mem_delay = 0;
    step();
    // An lsu owns the aborted transaction so rr_last would favour ifu without reset.
    bus.lsu_req  = 1'b1;
    bus.lsu_we   = 1'b0;
    bus.lsu_addr = 32'h50;
    #1;
    checks++;
    if (bus.lsu_gnt !== 1'b1) $display("FAIL rstmid_gnt: gnt=%b want 1", bus.lsu_gnt);
    else passes++;
    step();
    bus.lsu_req = 1'b0;
    step();
    #1;
    checks++;
    if (bus.mem_req !== 1'b1) $display("FAIL rstmid_busy2: req=%b want 1", bus.mem_req);
    else passes++;
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0)
      $display("FAIL rstmid_drop: req=%b rdata=%h err=%b want 0/0/0",
               bus.mem_req, bus.rsp_rdata, bus.rsp_err);
    else passes++;
    for (int n = 0; n < 4; n++) begin
      if (bus.lsu_done || bus.ifu_done || bus.ldr_done) n_done++;
      step();
      #1;
    end
    checks++;
    if (n_done !== 0) $display("FAIL rstmid_no_done: dones=%0d want 0", n_done);
    else passes++;
    mem_delay   = 1;
    mem_rdata_v = 32'h77;
    step();
    bus.lsu_req  = 1'b1;
    bus.lsu_addr = 32'h60;
    bus.ifu_req  = 1'b1;
    bus.ifu_addr = 32'h64;
    #1;
    wait_gnt(id, ok);
    checks++;
    if (!ok || id !== 1) $display("FAIL rstmid_tie: winner=%0d want 1", id);
    else passes++;
    step();
    bus.lsu_req = 1'b0;
    bus.ifu_req = 1'b0;
    step();
    step();
    ifu_txn(32'h68, 1, 32'h0000_0ABC, gnt_ok, n_req, n_done2, d_rdata, d_err);
    checks++;
    if (!gnt_ok || n_req !== 1 || n_done2 !== 1 || d_err !== 1'b0 || d_rdata !== 32'hABC)
      $display("FAIL rstmid_fetch: gnt=%b req=%0d done=%0d err=%b rdata=%h want 1/1/1/0/abc",
               gnt_ok, n_req, n_done2, d_err, d_rdata);
    else passes++;
  endtask

  initial begin
    bus.ldr_req   = 1'b0;
    bus.ldr_addr  = '0;
    bus.ldr_wdata = '0;
    bus.lsu_req   = 1'b0;
    bus.lsu_we    = 1'b0;
    bus.lsu_addr  = '0;
    bus.lsu_wdata = '0;
    bus.lsu_be    = '0;
    bus.ifu_req   = 1'b0;
    bus.ifu_addr  = '0;
    test_reset();
    test_fetch();
    test_round_robin();
    test_ldr_priority();
    test_store_delay();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, passed %0d of %0d",
             passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between three requesters: program loader (ldr), load/store unit (lsu) and instruction fetch (ifu).
Sits between the core and the memory inside the top-level package.
Arbitration is fixed priority for the loader, then round-robin between lsu and ifu.
Serialises transactions with a req/gnt/done handshake and a ready-timeout watchdog.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width
TIMEOUT, 16, max BUSY cycles waiting for mem_ready before abort (≥2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
ldr_req  in  1  loader write request (always full-word write)
ldr_addr  in  ADDR_W  loader address
ldr_wdata  in  DATA_W  loader write data
ldr_gnt  out  1  loader accepted (1-cycle pulse)
ldr_done  out  1  loader transaction complete (1-cycle pulse)
lsu_req  in  1  lsu request
lsu_we  in  1  1=store, 0=load
lsu_addr  in  ADDR_W  lsu address
lsu_wdata  in  DATA_W  store data
lsu_be  in  4  byte enables
lsu_gnt  out  1  lsu accepted
lsu_done  out  1  lsu complete
ifu_req  in  1  fetch request (read-only)
ifu_addr  in  ADDR_W  fetch address
ifu_gnt  out  1  fetch accepted
ifu_done  out  1  fetch complete
rsp_rdata  out  DATA_W  read data, valid with lsu_done/ifu_done on a read
rsp_err  out  1  timeout abort flag, valid with any *_done
mem_req  out  1  memory request, held until mem_ready or abort
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  4  memory byte enables
mem_ready  in  1  memory completion; read data valid this cycle
mem_rdata  in  DATA_W  memory read data

Behaviour:
- FSM states: IDLE, BUSY, RESP.
- Reset: state=IDLE; all gnt/done=0; mem_req=0; mem_we/addr/wdata/be=0; rsp_rdata=0; rsp_err=0; rr_last=IFU, so the lsu wins the first tie; watchdog=0.
- Reset mid-transaction drops it: mem_req falls the next cycle and no done pulse is issued.
- IDLE:
  - If any req is high, pick a winner: ldr > (lsu vs ifu by round-robin; winner is the one not equal to rr_last).
  - Winner's gnt is combinational, in the same cycle.
  - Register the command: ldr forces we=1, be=4'hF; ifu forces we=0, be=4'hF.
  - Go to BUSY. Only lsu/ifu wins update rr_last.
- Requesters hold req and payload stable until gnt. Payload is sampled only at gnt; later changes are ignored.
- BUSY:
  - mem_req=1 with the latched command, stable throughout.
  - On mem_ready: capture mem_rdata into rsp_rdata if read, rsp_err=0, go to RESP.
  - Watchdog counts BUSY cycles. If it reaches TIMEOUT without mem_ready: rsp_err=1, rsp_rdata=0, go to RESP.
  - mem_req=0 in RESP.
  - mem_ready sampled in IDLE or RESP is ignored.
- RESP: done pulses for exactly one cycle to the owning requester; rsp_rdata/rsp_err are held until the next RESP; go to IDLE.
- Latency with a 1-cycle memory: gnt at T, mem_req at T+1, done at T+2, next gnt at T+3 at the earliest.
- No gnt is issued outside IDLE. Requests arriving in BUSY/RESP wait.
- Writes: rsp_rdata is left unchanged. be=0 still performs a transaction and pulses done.
- Addresses are passed unmodified; no alignment check.

Decomposition:
- Shared package: requester-ID constants (REQ_LDR=2'd0, REQ_LSU=2'd1, REQ_IFU=2'd2), state encodings, full-word BE constant 4'hF.
- One sub-module, rr_pick2: combinational 2-way round-robin picker (inputs lsu_req, ifu_req, rr_last; output winner).
- FSM, watchdog and command registers stay in the top.

Test Plan:
- Reset, then ifu_req with ifu_addr=0x10 and mem_ready one cycle after mem_req, mem_rdata=0x00000513 -> ifu_gnt at T, mem_req T+1, ifu_done T+2, rsp_rdata=0x00000513, rsp_err=0.
- lsu_req and ifu_req both held continuously -> grants alternate lsu, ifu, lsu, ifu; the lsu goes first after reset.
- ldr_req with lsu/ifu pending, ldr_addr=0x4, ldr_wdata=0xDEADBEEF -> ldr wins; mem_we=1, mem_be=F, mem_wdata=0xDEADBEEF. Next lsu/ifu order is unaffected.
- lsu store we=1, be=4'b0011, addr=0x8, wdata=0x1234ABCD; mem_ready delayed 5 cycles -> mem_req held 5 cycles with a stable payload; lsu_done once; rsp_rdata unchanged.
- mem_ready never asserted (TIMEOUT=16) -> exactly 16 BUSY cycles, then done with rsp_err=1, rsp_rdata=0; the next transaction completes with rsp_err=0.
- rst asserted on the 2nd BUSY cycle -> mem_req=0 the next cycle, no done pulse, state IDLE. A later ifu_req is serviced normally, and the lsu wins the first subsequent tie.
